// File: rtl/alu_dispatch_if.sv
// Request, ALU-drive and response bundle for alu_dispatch.
// The master side is the issue/ALU/writeback environment; the slave side is the dispatcher.
interface alu_dispatch_if #(
  parameter int DATA_WIDTH = 64,
  parameter int SHIFT_AMT  = $clog2(DATA_WIDTH),
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  req_valid;
  logic                  req_ready;
  logic [4:0]            req_func;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic [SHIFT_AMT-1:0]  req_shift;
  logic [TAG_WIDTH-1:0]  req_tag;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [SHIFT_AMT-1:0]  alu_shift;
  logic [4:0]            alu_func;
  logic [DATA_WIDTH-1:0] alu_result;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  rsp_illegal;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output flush, req_valid, req_func,
    output req_a, req_b, req_shift, req_tag,
    output alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b,
    input  alu_shift, alu_func,
    input  rsp_valid, rsp_data, rsp_tag,
    input  rsp_illegal, occupancy
  );

  modport slave (
    input  flush, req_valid, req_func,
    input  req_a, req_b, req_shift, req_tag,
    input  alu_result, rsp_ready,
    output req_ready, alu_a, alu_b,
    output alu_shift, alu_func,
    output rsp_valid, rsp_data, rsp_tag,
    output rsp_illegal, occupancy
  );
endinterface

// File: rtl/alu_dispatch.sv
// Issue-side ALU front end: request FIFO feeding the combinational ALU,
// with a registered response stage decoupling writeback back-pressure.
module alu_dispatch #(
  parameter int DATA_WIDTH = 64,
  parameter int SHIFT_AMT  = $clog2(DATA_WIDTH),
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_dispatch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [4:0]            r_func  [DEPTH];
  logic [DATA_WIDTH-1:0] r_a     [DEPTH];
  logic [DATA_WIDTH-1:0] r_b     [DEPTH];
  logic [SHIFT_AMT-1:0]  r_shift [DEPTH];
  logic [TAG_WIDTH-1:0]  r_tag   [DEPTH];

  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [OW-1:0]         r_occ;
  logic                  r_en;

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic                  r_rsp_ill;

  logic w_empty;
  logic w_full;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_ill;

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == OW'(DEPTH));
  // r_en keeps req_ready low until the first edge after reset release
  assign w_ready = r_en & ~w_full & ~bus.flush;
  assign w_push  = bus.req_valid & w_ready;
  assign w_pop   = ~w_empty
                 & (~r_rsp_valid | bus.rsp_ready)
                 & ~bus.flush;
  assign w_ill   = r_func[r_rptr] > 5'b01001;

  assign bus.req_ready   = w_ready;
  assign bus.occupancy   = r_occ;
  assign bus.alu_a       = w_empty ? '0 : r_a[r_rptr];
  assign bus.alu_b       = w_empty ? '0 : r_b[r_rptr];
  assign bus.alu_shift   = w_empty ? '0 : r_shift[r_rptr];
  assign bus.alu_func    = w_empty ? '0 : r_func[r_rptr];
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_tag     = r_rsp_tag;
  assign bus.rsp_illegal = r_rsp_ill;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_func[r_wptr]  <= bus.req_func;
      r_a[r_wptr]     <= bus.req_a;
      r_b[r_wptr]     <= bus.req_b;
      r_shift[r_wptr] <= bus.req_shift;
      r_tag[r_wptr]   <= bus.req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= 1'b0;
    end else begin
      r_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else if (bus.flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case (1'b1)
        (w_push & ~w_pop): r_occ <= r_occ + OW'(1);
        (w_pop & ~w_push): r_occ <= r_occ - OW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_rsp_ill   <= 1'b0;
    end else if (bus.flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_pop) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_ill ? '0 : bus.alu_result;
      r_rsp_tag   <= r_tag[r_rptr];
      r_rsp_ill   <= w_ill;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end
endmodule
